data_mem_unit: RTL and testbench

DATA_MEM_UNIT -- requirements
Module: data_mem_unit

---
 rtl/mem_pkg.sv | 43 ++++
 rtl/load_align.sv | 42 ++++
 rtl/data_mem_unit.sv | 159 +++++++++++++++
 tb/tb_data_mem_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
//   Shared decode constants for the data memory unit. Control/ImmGen decode
//   also uses these constants.
//   - F3_*      : RV32 load/store width codes (funct3)
//   - state_t   : data memory unit FSM states
//   - access_fault() : funct3 legality and alignment check for one access
//                      (the address range check depends on DEPTH and is done
//                      by the instantiating module)
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Unsigned widths exist only for loads, so a store using them is illegal.
    // Codes that are not listed are always illegal.
    function automatic logic access_fault(input logic [2:0] funct3,
                                          input logic       write,
                                          input logic [1:0] lane);
        logic w_fault;
        w_fault = 1'b1;
        case (funct3)
            F3_B:    w_fault = 1'b0;
            F3_BU:   w_fault = write;
            F3_H:    w_fault = lane[0];
            F3_HU:   w_fault = write | lane[0];
            F3_W:    w_fault = (lane != 2'b00);
            default: w_fault = 1'b1;
        endcase
        return w_fault;
    endfunction

endpackage

// File: rtl/load_align.sv
// -----------------------------------------------------------------------------
// load_align
//   Combinational lane select and extension for loads.
//   Ports:
//     word   : full memory word read at the word index
//     lane   : byte offset within the word (addr[1:0])
//     funct3 : width code (B/H sign-extend, BU/HU zero-extend, W as-is)
//     result : XLEN-bit load value, 0 for codes that are not loads
// -----------------------------------------------------------------------------
module load_align
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      lane,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = word[{lane, 3'b000} +: 8];
    // Halfwords are aligned, so only lane[1] chooses the half.
    assign w_half = word[{lane[1], 4'b0000} +: 16];

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        result = '0;
        case (funct3)
            F3_B:    result = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_BU:   result = XLEN'(w_byte);
            F3_H:    result = {{(XLEN-16){w_half[15]}}, w_half};
            F3_HU:   result = XLEN'(w_half);
            F3_W:    result = word;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_unit.sv
// -----------------------------------------------------------------------------
// data_mem_unit
//   Byte-addressed data memory with a valid/ready request channel and a
//   valid/ready response channel, one access in flight.
//   Ports:
//     clk, reset_n            : clock, asynchronous active-low reset
//     req_valid / req_ready   : request handshake (ready only in IDLE)
//     req_write               : 1 = store, 0 = load
//     req_funct3              : RV32 width code
//     req_addr / req_wdata    : byte address, right-aligned store data
//     rsp_valid / rsp_ready   : response handshake
//     rsp_rdata               : load result (0 for stores and faults)
//     rsp_fault               : misaligned, out-of-range or illegal funct3
//   Legal accesses answer LATENCY cycles after accept; faults answer after one.
// -----------------------------------------------------------------------------
module data_mem_unit
    import mem_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_fault
);

    localparam int               IDX_W      = $clog2(DEPTH);
    localparam int               CNT_W      = 3;
    localparam logic [XLEN-1:0]  ADDR_LIMIT = XLEN'(DEPTH * 4);
    localparam logic [CNT_W-1:0] CNT_INIT   = CNT_W'(LATENCY - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_live;      // first edge after reset has happened
    logic             r_write;
    logic [2:0]       r_funct3;
    logic [IDX_W-1:0] r_idx;
    logic [1:0]       r_lane;
    logic [XLEN-1:0]  r_wdata;
    logic             r_fault;
    logic [XLEN-1:0]  r_rsp_rdata;
    logic             r_rsp_fault;
    logic [XLEN-1:0]  r_mem [DEPTH];

    logic             w_accept;
    logic             w_fault;
    logic             w_done;
    logic [XLEN-1:0]  w_rd_word;
    logic [XLEN-1:0]  w_load_data;
    logic [XLEN-1:0]  w_mask;
    logic [XLEN-1:0]  w_wshift;

    assign req_ready = r_live && (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_fault = r_rsp_fault;

    assign w_accept  = req_valid && req_ready;
    assign w_fault   = access_fault(req_funct3, req_write, req_addr[1:0])
                       || (req_addr >= ADDR_LIMIT);
    // The single edge on which the access takes effect and the response forms.
    assign w_done    = (r_state == WAIT) && (r_cnt == '0);
    assign w_rd_word = r_mem[r_idx];

    load_align #(.XLEN(XLEN)) u_load_align (
        .word   (w_rd_word),
        .lane   (r_lane),
        .funct3 (r_funct3),
        .result (w_load_data)
    );

    // Store lane mask and data moved into lane position.
    always_comb begin
        w_mask   = '0;
        w_wshift = '0;
        case (r_funct3)
            F3_B: begin
                w_mask   = XLEN'(8'hFF) << {r_lane, 3'b000};
                w_wshift = XLEN'(r_wdata[7:0]) << {r_lane, 3'b000};
            end
            F3_H: begin
                w_mask   = XLEN'(16'hFFFF) << {r_lane[1], 4'b0000};
                w_wshift = XLEN'(r_wdata[15:0]) << {r_lane[1], 4'b0000};
            end
            F3_W: begin
                w_mask   = '1;
                w_wshift = r_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = WAIT;
            WAIT:    if (r_cnt == '0) w_state_next = RESP;
            RESP:    if (rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_live      <= 1'b0;
            r_write     <= 1'b0;
            r_funct3    <= '0;
            r_idx       <= '0;
            r_lane      <= '0;
            r_wdata     <= '0;
            r_fault     <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_fault <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_live  <= 1'b1;
            if (w_accept) begin
                r_write  <= req_write;
                r_funct3 <= req_funct3;
                r_idx    <= req_addr[IDX_W+1:2];
                r_lane   <= req_addr[1:0];
                r_wdata  <= req_wdata;
                r_fault  <= w_fault;
                // A fault spends exactly one cycle in WAIT, touching nothing.
                r_cnt    <= w_fault ? '0 : CNT_INIT;
            end else if ((r_state == WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_done) begin
                r_rsp_fault <= r_fault;
                r_rsp_rdata <= (r_write || r_fault) ? '0 : w_load_data;
            end
        end
    end

    // NOTE: the storage array has no reset; contents survive reset_n, and a
    // reset during WAIT drops the store because the state leaves WAIT first.
    always_ff @(posedge clk) begin
        if (w_done && r_write && !r_fault) begin
            r_mem[r_idx] <= (w_rd_word & ~w_mask) | (w_wshift & w_mask);
        end
    end

endmodule

// File: tb/tb_data_mem_unit.sv
// -----------------------------------------------------------------------------
// tb_data_mem_unit
//   Self-checking bench: directed vector table, random traffic against a
//   byte-array reference model, and hand sequences for backpressure and
//   reset during an in-flight store.
// -----------------------------------------------------------------------------
module tb_data_mem_unit;
    import mem_pkg::*;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 256;
    localparam int          LAT   = 2;
    localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic        req_valid  = 1'b0;
    logic        req_ready;
    logic        req_write  = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr   = '0;
    logic [31:0] req_wdata  = '0;
    logic        rsp_valid;
    logic        rsp_ready  = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference memory as plain bytes, little-endian.
    logic [7:0] m [DEPTH*4];

    typedef struct {
        logic        write;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[$];

    data_mem_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic m_fault(input logic w, input logic [2:0] f3, input logic [31:0] a);
        if (a >= LIMIT) return 1'b1;
        case (f3)
            3'b000:  return 1'b0;
            3'b100:  return w;
            3'b001:  return a[0];
            3'b101:  return w | a[0];
            3'b010:  return a[1:0] != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
        int i;
        i = int'(a);
        case (f3)
            3'b000:  return {{24{m[i][7]}}, m[i]};
            3'b100:  return {24'h0, m[i]};
            3'b001:  return {{16{m[i+1][7]}}, m[i+1], m[i]};
            3'b101:  return {16'h0, m[i+1], m[i]};
            3'b010:  return {m[i+3], m[i+2], m[i+1], m[i]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int i;
        int n;
        i = int'(a);
        n = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
        for (int k = 0; k < n; k++) m[i+k] = wd[8*k +: 8];
    endtask

    // Called at a negedge; returns just after the accept edge (ok=1).
    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output bit ok);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
    endtask

    // Counts rising edges after the accept edge until rsp_valid is seen.
    task automatic await_rsp(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (rsp_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic xact(input string name, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_f);
        bit ok;
        int lat;
        issue(w, f3, a, wd, ok);
        check($sformatf("%s accept", name), 32'(ok), 32'd1);
        if (ok) begin
            await_rsp(lat);
            check($sformatf("%s latency", name), 32'(lat), exp_f ? 32'd1 : 32'(LAT));
            check($sformatf("%s rdata", name), rsp_rdata, exp_rd);
            check($sformatf("%s fault", name), 32'(rsp_fault), 32'(exp_f));
        end
        if (!m_fault(w, f3, a) && w) m_store(f3, a, wd);
    endtask

    initial begin
        bit          ok;
        int          lat;
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic        ef;
        logic [31:0] erd;
        logic [31:0] prior;

        // write, funct3, addr, wdata, expected rdata, expected fault
        vecs.push_back('{1'b1, F3_W,   32'h010, 32'hDEADBEEF, 32'h00000000, 1'b0});
        vecs.push_back('{1'b0, F3_W,   32'h010, 32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, F3_B,   32'h011, 32'h00000080, 32'h00000000, 1'b0});
        vecs.push_back('{1'b0, F3_B,   32'h011, 32'h0,        32'hFFFFFF80, 1'b0});
        vecs.push_back('{1'b0, F3_BU,  32'h011, 32'h0,        32'h00000080, 1'b0});
        vecs.push_back('{1'b0, F3_W,   32'h010, 32'h0,        32'hDEAD80EF, 1'b0});
        vecs.push_back('{1'b0, F3_H,   32'h003, 32'h0,        32'h00000000, 1'b1});
        vecs.push_back('{1'b0, F3_W,   32'h012, 32'h0,        32'h00000000, 1'b1});
        vecs.push_back('{1'b0, F3_W,   32'h010, 32'h0,        32'hDEAD80EF, 1'b0});
        vecs.push_back('{1'b0, F3_W,   LIMIT,   32'h0,        32'h00000000, 1'b1});
        vecs.push_back('{1'b1, F3_BU,  32'h010, 32'h11223344, 32'h00000000, 1'b1});
        vecs.push_back('{1'b1, F3_HU,  32'h010, 32'h11223344, 32'h00000000, 1'b1});
        vecs.push_back('{1'b1, 3'b110, 32'h010, 32'h11223344, 32'h00000000, 1'b1});
        vecs.push_back('{1'b0, 3'b011, 32'h010, 32'h0,        32'h00000000, 1'b1});
        vecs.push_back('{1'b1, F3_W,   32'h013, 32'h55555555, 32'h00000000, 1'b1});
        vecs.push_back('{1'b0, F3_W,   32'h010, 32'h0,        32'hDEAD80EF, 1'b0});
        vecs.push_back('{1'b1, F3_H,   32'h012, 32'h0000ABCD, 32'h00000000, 1'b0});
        vecs.push_back('{1'b0, F3_HU,  32'h012, 32'h0,        32'h0000ABCD, 1'b0});
        vecs.push_back('{1'b0, F3_H,   32'h012, 32'h0,        32'hFFFFABCD, 1'b0});
        vecs.push_back('{1'b0, F3_W,   32'h010, 32'h0,        32'hABCD80EF, 1'b0});
        vecs.push_back('{1'b0, F3_BU,  32'h013, 32'h0,        32'h000000AB, 1'b0});
        vecs.push_back('{1'b0, F3_B,   32'h010, 32'h0,        32'hFFFFFFEF, 1'b0});
        vecs.push_back('{1'b1, F3_B,   LIMIT-1, 32'h0000005A, 32'h00000000, 1'b0});
        vecs.push_back('{1'b0, F3_BU,  LIMIT-1, 32'h0,        32'h0000005A, 1'b0});

        // Reset state
        #12;
        check("reset req_ready", 32'(req_ready), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_rdata", rsp_rdata, 32'd0);
        check("reset rsp_fault", 32'(rsp_fault), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("ready before first edge", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        check("ready after first edge", 32'(req_ready), 32'd1);

        // Directed vectors
        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            xact($sformatf("vec%0d", i), vecs[i].write, vecs[i].f3, vecs[i].addr,
                 vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_fault);
        end

        // Give every word a known value before random traffic
        for (int i = 0; i < DEPTH; i++) begin
            wd = $urandom;
            xact($sformatf("fill%0d", i), 1'b1, F3_W, 32'(i * 4), wd, 32'h0, 1'b0);
        end

        // Random traffic against the byte model
        for (int i = 0; i < 300; i++) begin
            w  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) a = LIMIT + 32'($urandom_range(0, 4095));
            else                           a = 32'($urandom_range(0, DEPTH * 4 - 1));
            wd  = $urandom;
            ef  = m_fault(w, f3, a);
            erd = (ef || w) ? 32'h0 : m_load(f3, a);
            xact($sformatf("rnd%0d", i), w, f3, a, wd, erd, ef);
        end

        // Response backpressure with a second request waiting
        @(negedge clk);
        rsp_ready = 1'b0;
        erd = m_load(F3_W, 32'h10);
        issue(1'b0, F3_W, 32'h10, 32'h0, ok);
        check("bp accept", 32'(ok), 32'd1);
        await_rsp(lat);
        check("bp latency", 32'(lat), 32'(LAT));
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = F3_W;
        req_addr   = 32'h24;
        req_wdata  = 32'hCAFEF00D;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bp%0d rsp_valid", k), 32'(rsp_valid), 32'd1);
            check($sformatf("bp%0d rdata", k), rsp_rdata, erd);
            check($sformatf("bp%0d fault", k), 32'(rsp_fault), 32'd0);
            check($sformatf("bp%0d req_ready", k), 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp after handshake rsp_valid", 32'(rsp_valid), 32'd0);
        check("bp after handshake req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        await_rsp(lat);
        check("bp second latency", 32'(lat), 32'(LAT));
        check("bp second fault", 32'(rsp_fault), 32'd0);
        m_store(F3_W, 32'h24, 32'hCAFEF00D);
        xact("bp readback", 1'b0, F3_W, 32'h24, 32'h0, 32'hCAFEF00D, 1'b0);

        // Reset during WAIT abandons the store
        @(negedge clk);
        prior = m_load(F3_W, 32'h20);
        issue(1'b1, F3_W, 32'h20, 32'h12345678, ok);
        check("rst accept", 32'(ok), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst req_ready", 32'(req_ready), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_rdata", rsp_rdata, 32'd0);
        check("rst rsp_fault", 32'(rsp_fault), 32'd0);
        @(posedge clk);
        #1;
        check("rst held req_ready", 32'(req_ready), 32'd0);
        check("rst held rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst release req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        check("rst first edge req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        xact("rst readback", 1'b0, F3_W, 32'h20, 32'h0, prior, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
